ats21_cmd_issuer: RTL

- Upstream feeder for the ATS21 scheduler; owns the ATS21 req/ctrlA/ctrlB command bus.
- Buffers 32-bit instructions from client A and client B in two independent FIFOs.
- Serializes each pair into the ATS21 protocol: a one-cycle req pulse, then the upper halves, then the lower halves, then a fixed gap.
- A client lane with nothing pending is driven with a NOP (opcode 000, all zero).

---
 rtl/ats21_cmd_issuer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ats21_cmd_issuer.sv
// ATS21 command issuer: buffers client A/B instructions in two FIFOs and
// serializes them onto the ATS21 req/ctrlA/ctrlB bus (req, high halves, low halves, gap).
module ats21_cmd_issuer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [31:0]   a_instr,
  output logic          a_accept,
  input  logic          b_valid,
  input  logic [31:0]   b_instr,
  output logic          b_accept,
  input  logic          dut_ready,
  output logic          req,
  output logic [15:0]   ctrlA,
  output logic [15:0]   ctrlB,
  output logic          busy,
  output logic [LW-1:0] a_level,
  output logic [LW-1:0] b_level
);

  localparam int unsigned NL = 2;
  localparam int unsigned IW = 32;
  localparam int unsigned HW = 16;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, REQ, HI, LO, GAP} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          req_q, req_d;
  logic [HW-1:0] ctrl_q [NL];
  logic [HW-1:0] ctrl_d [NL];
  logic [IW-1:0] head_q [NL];
  logic [IW-1:0] head_d [NL];
  logic [NL-1:0] sel_q, sel_d;

  logic [IW-1:0] mem_q    [NL][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NL];
  logic [PW-1:0] wr_ptr_d [NL];
  logic [PW-1:0] rd_ptr_q [NL];
  logic [PW-1:0] rd_ptr_d [NL];
  logic [LW-1:0] level_q  [NL];
  logic [LW-1:0] level_d  [NL];
  logic [IW-1:0] in_instr [NL];
  logic [NL-1:0] in_valid, full, empty, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_valid    = {b_valid, a_valid};
  assign in_instr[0] = a_instr;
  assign in_instr[1] = b_instr;

  // FIFO bookkeeping; pops happen only in LO for the lanes latched at the request
  always_comb begin
    for (int i = 0; i < int'(NL); i++) begin
      full[i]     = (level_q[i] == LW'(FIFO_DEPTH));
      empty[i]    = (level_q[i] == '0);
      push[i]     = in_valid[i] && !full[i];
      pop[i]      = (state_q == LO) && sel_q[i];
      wr_ptr_d[i] = push[i] ? next_ptr(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i] ? next_ptr(rd_ptr_q[i]) : rd_ptr_q[i];
      level_d[i]  = level_q[i];
      if (push[i] && !pop[i]) begin
        level_d[i] = level_q[i] + LW'(1);
      end else if (pop[i] && !push[i]) begin
        level_d[i] = level_q[i] - LW'(1);
      end
    end
  end

  // Sequencer; bus outputs are derived from the next state so they align with state_q
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    head_d  = head_q;
    req_d   = 1'b0;
    for (int i = 0; i < int'(NL); i++) ctrl_d[i] = '0;

    case (state_q)
      IDLE: begin
        if (dut_ready && (empty != '1)) begin
          state_d = REQ;
          sel_d   = ~empty;
          for (int i = 0; i < int'(NL); i++) head_d[i] = mem_q[i][rd_ptr_q[i]];
        end
      end
      REQ:     state_d = HI;
      HI:      state_d = LO;
      LO: begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < int'(NL); i++) begin
      case (state_d)
        HI:      ctrl_d[i] = sel_d[i] ? head_d[i][IW-1:HW] : '0;
        LO:      ctrl_d[i] = sel_d[i] ? head_d[i][HW-1:0] : '0;
        GAP:     ctrl_d[i] = ctrl_q[i];
        default: ctrl_d[i] = '0;
      endcase
    end
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      req_q   <= 1'b0;
      sel_q   <= '0;
      for (int i = 0; i < int'(NL); i++) begin
        ctrl_q[i]   <= '0;
        head_q[i]   <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        level_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      for (int i = 0; i < int'(NL); i++) begin
        ctrl_q[i]   <= ctrl_d[i];
        head_q[i]   <= head_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        level_q[i]  <= level_d[i];
      end
    end
  end

  // Storage needs no reset: reads are gated by the level counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NL); i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_instr[i];
    end
  end

  assign req      = req_q;
  assign ctrlA    = ctrl_q[0];
  assign ctrlB    = ctrl_q[1];
  assign busy     = (state_q != IDLE);
  assign a_level  = level_q[0];
  assign b_level  = level_q[1];
  assign a_accept = !full[0];
  assign b_accept = !full[1];

endmodule
